// File: rtl/uc_pkg.sv
// Shared constants for the unidade_controle control unit: instruction field
// widths, opcodes, the pass-A ALU code, FSM state encoding and the decoded
// instruction record. Optional branch support is selected by UC_DESVIO_EN.
package uc_pkg;

  localparam int INSTR_W = 16;
  localparam int OPC_W   = 4;
  localparam int REG_W   = 4;
  localparam int IMM_W   = 8;
  localparam int PC_W    = 16;

  localparam logic [OPC_W-1:0] OPC_ADD  = 4'h0;
  localparam logic [OPC_W-1:0] OPC_SUB  = 4'h1;
  localparam logic [OPC_W-1:0] OPC_AND  = 4'h2;
  localparam logic [OPC_W-1:0] OPC_OR   = 4'h3;
  localparam logic [OPC_W-1:0] OPC_XOR  = 4'h4;
  localparam logic [OPC_W-1:0] OPC_SHL  = 4'h5;
  localparam logic [OPC_W-1:0] OPC_SHR  = 4'h6;
  localparam logic [OPC_W-1:0] OPC_ADDI = 4'h7;
  localparam logic [OPC_W-1:0] OPC_LI   = 4'h8;
  localparam logic [OPC_W-1:0] OPC_JMP  = 4'h9;
  localparam logic [OPC_W-1:0] OPC_BEQZ = 4'hA;
  localparam logic [OPC_W-1:0] OPC_HALT = 4'hF;

  // ALU code that forwards operand A unchanged (shared by LI and BEQZ)
  localparam logic [OPC_W-1:0] OP_PASS_A = 4'h8;

  localparam logic [2:0] ST_BUSCA      = 3'd0;
  localparam logic [2:0] ST_DECODIFICA = 3'd1;
  localparam logic [2:0] ST_EXECUTA    = 3'd2;
  localparam logic [2:0] ST_ESCRITA    = 3'd3;
  localparam logic [2:0] ST_PARADO     = 3'd4;

  typedef struct packed {
    logic [REG_W-1:0] rc;
    logic [REG_W-1:0] ra;
    logic [REG_W-1:0] rb;
    logic [PC_W-1:0]  imediato;
    logic             flag_imm;
    logic             ula_en;
    logic [OPC_W-1:0] op_ula;
    logic             escreve;
    logic             halt;
`ifdef UC_DESVIO_EN
    logic             salto;
    logic             desvio_cond;
`endif
  } dec_t;

  function automatic logic [PC_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(PC_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/uc_decodificador.sv
// Combinational field split and opcode decode for unidade_controle.
// With UC_DESVIO_EN undefined, JMP and BEQZ decode as NOP.
module uc_decodificador
  import uc_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output dec_t               dec
);

  logic [OPC_W-1:0] opcode;
  assign opcode = instr[15:12];

  // Split fields and derive the per-opcode control bits
  always_comb begin
    dec          = '0;
    dec.rc       = instr[11:8];
    dec.ra       = instr[7:4];
    dec.rb       = instr[3:0];
    dec.imediato = sext_imm(instr[7:0]);
    case (opcode)
      OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_XOR, OPC_SHL, OPC_SHR: begin
        dec.ula_en  = 1'b1;
        dec.op_ula  = opcode;
        dec.escreve = 1'b1;
      end
      OPC_ADDI: begin
        dec.ula_en   = 1'b1;
        dec.op_ula   = opcode;
        dec.escreve  = 1'b1;
        dec.flag_imm = 1'b1;
      end
      OPC_LI: begin
        dec.ula_en   = 1'b1;
        dec.op_ula   = OP_PASS_A;
        dec.escreve  = 1'b1;
        dec.flag_imm = 1'b1;
      end
`ifdef UC_DESVIO_EN
      OPC_JMP: begin
        dec.salto = 1'b1;
      end
      OPC_BEQZ: begin
        dec.op_ula      = OP_PASS_A;
        dec.desvio_cond = 1'b1;
      end
`endif
      OPC_HALT: begin
        dec.halt = 1'b1;
      end
      default: begin
        dec.ula_en = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/unidade_controle.sv
// unidade_controle: four-state fetch/decode/execute/write control unit with
// program counter and a terminal PARADO state entered by HALT.
// Build option: define UC_DESVIO_EN to enable JMP/BEQZ and the branch adder.
module unidade_controle
  import uc_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valido,
  output logic               instr_aceita,
  output logic [PC_W-1:0]    pc,
  input  logic               ula_zero,
  output logic [REG_W-1:0]   regA,
  output logic [REG_W-1:0]   regB,
  output logic [REG_W-1:0]   regC,
  output logic               RW,
  output logic [PC_W-1:0]    imediato,
  output logic               flagImediato,
  output logic [OPC_W-1:0]   op_ula,
  output logic               ula_en,
  output logic               parado
);

  logic [2:0]         state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  dec_t               dec;

  uc_decodificador u_dec (
    .instr (instr_q),
    .dec   (dec)
  );

`ifdef UC_DESVIO_EN
  logic [PC_W-1:0] pc_desvio;
  logic            toma_desvio;
  assign pc_desvio   = pc_q + dec.imediato;
  assign toma_desvio = dec.salto | (dec.desvio_cond & ula_zero);
`else
  logic unused_ula_zero;
  assign unused_ula_zero = ula_zero;
`endif

  // Next-state, program counter and instruction latch
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      ST_BUSCA: begin
        if (instr_valido) begin
          instr_d = instr;
          pc_d    = pc_q + 16'd1;
          state_d = ST_DECODIFICA;
        end
      end
      ST_DECODIFICA: state_d = ST_EXECUTA;
      ST_EXECUTA: begin
`ifdef UC_DESVIO_EN
        if (toma_desvio) pc_d = pc_desvio;
`endif
        state_d = dec.halt ? ST_PARADO : ST_ESCRITA;
      end
      ST_ESCRITA: state_d = ST_BUSCA;
      ST_PARADO:  state_d = ST_PARADO;
      default:    state_d = ST_BUSCA;
    endcase
  end

  // State registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BUSCA;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Outputs decoded from the current state and the latched instruction
  always_comb begin
    instr_aceita = rst_n & (state_q == ST_BUSCA) & instr_valido;
    pc           = pc_q;
    regA         = '0;
    regB         = '0;
    regC         = '0;
    RW           = 1'b0;
    imediato     = '0;
    flagImediato = 1'b0;
    op_ula       = '0;
    ula_en       = 1'b0;
    parado       = (state_q == ST_PARADO);
    if (state_q == ST_DECODIFICA || state_q == ST_EXECUTA) begin
      regA         = dec.ra;
      regB         = dec.rb;
      imediato     = dec.imediato;
      flagImediato = dec.flag_imm;
    end
    if (state_q == ST_EXECUTA) begin
      op_ula = dec.op_ula;
      ula_en = dec.ula_en;
    end
    if (state_q == ST_ESCRITA && dec.escreve) begin
      regC = dec.rc;
      // r0 is hard-wired, so a write addressed to it is suppressed
      RW   = (dec.rc != '0);
    end
  end

endmodule

// File: tb/tb_unidade_controle.sv
// Directed self-checking bench for unidade_controle. Branch checks follow the
// UC_DESVIO_EN build option.
module tb_unidade_controle;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] instr;
  logic        instr_valido;
  logic        instr_aceita;
  logic [15:0] pc;
  logic        ula_zero;
  logic [3:0]  regA, regB, regC;
  logic        RW;
  logic [15:0] imediato;
  logic        flagImediato;
  logic [3:0]  op_ula;
  logic        ula_en;
  logic        parado;

  int n_cmp = 0;
  int n_err = 0;

  unidade_controle dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr        (instr),
    .instr_valido (instr_valido),
    .instr_aceita (instr_aceita),
    .pc           (pc),
    .ula_zero     (ula_zero),
    .regA         (regA),
    .regB         (regB),
    .regC         (regC),
    .RW           (RW),
    .imediato     (imediato),
    .flagImediato (flagImediato),
    .op_ula       (op_ula),
    .ula_en       (ula_en),
    .parado       (parado)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Entered just after a negedge with the DUT in BUSCA; leaves it in BUSCA.
  task automatic run_instr(input string tag, input logic [15:0] i, input logic z,
                           input logic [3:0] ea, input logic [3:0] eb,
                           input logic [15:0] eimm, input logic ef,
                           input logic een, input logic [3:0] eop,
                           input logic erw, input logic [3:0] ec,
                           input logic [15:0] epc_dec, input logic [15:0] epc);
    instr = i; instr_valido = 1'b1; ula_zero = z;
    #1 chk({tag, ".aceita"}, {15'd0, instr_aceita}, 16'd1);
    @(negedge clk);
    instr_valido = 1'b0; instr = 16'hFFFF;
    chk({tag, ".regA"}, {12'd0, regA}, {12'd0, ea});
    chk({tag, ".regB"}, {12'd0, regB}, {12'd0, eb});
    chk({tag, ".imediato"}, imediato, eimm);
    chk({tag, ".flagImediato"}, {15'd0, flagImediato}, {15'd0, ef});
    chk({tag, ".dec.RW"}, {15'd0, RW}, 16'd0);
    chk({tag, ".dec.pc"}, pc, epc_dec);
    @(negedge clk);
    chk({tag, ".ula_en"}, {15'd0, ula_en}, {15'd0, een});
    chk({tag, ".op_ula"}, {12'd0, op_ula}, {12'd0, eop});
    chk({tag, ".exe.RW"}, {15'd0, RW}, 16'd0);
    @(negedge clk);
    chk({tag, ".RW"}, {15'd0, RW}, {15'd0, erw});
    chk({tag, ".regC"}, {12'd0, regC}, {12'd0, ec});
    chk({tag, ".esc.ula_en"}, {15'd0, ula_en}, 16'd0);
    chk({tag, ".pc"}, pc, epc);
    @(negedge clk);
    chk({tag, ".busca.RW"}, {15'd0, RW}, 16'd0);
    chk({tag, ".busca.aceita"}, {15'd0, instr_aceita}, 16'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; instr_valido = 1'b1;
    #1;
    chk("rst.pc", pc, 16'd0);
    chk("rst.RW", {15'd0, RW}, 16'd0);
    chk("rst.aceita", {15'd0, instr_aceita}, 16'd0);
    chk("rst.parado", {15'd0, parado}, 16'd0);
    chk("rst.ula_en", {15'd0, ula_en}, 16'd0);
    chk("rst.regA", {12'd0, regA}, 16'd0);
    @(negedge clk);
    instr_valido = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    instr = '0; instr_valido = 1'b0; ula_zero = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    do_reset();

    //          tag    instr     z  ra    rb    imm       f  en op    rw rc    pcD       pc
    run_instr("ADD",  16'h0312, 0, 4'h1, 4'h2, 16'h0012, 0, 1, 4'h0, 1, 4'h3, 16'h0001, 16'h0001);
    run_instr("SUB",  16'h1431, 0, 4'h3, 4'h1, 16'h0031, 0, 1, 4'h1, 1, 4'h4, 16'h0002, 16'h0002);
    run_instr("ADDI", 16'h75FE, 0, 4'hF, 4'hE, 16'hFFFE, 1, 1, 4'h7, 1, 4'h5, 16'h0003, 16'h0003);
    run_instr("LIr0", 16'h8080, 0, 4'h8, 4'h0, 16'hFF80, 1, 1, 4'h8, 0, 4'h0, 16'h0004, 16'h0004);
    run_instr("NOP",  16'hB123, 0, 4'h2, 4'h3, 16'h0023, 0, 0, 4'h0, 0, 4'h0, 16'h0005, 16'h0005);
`ifdef UC_DESVIO_EN
    do_reset();
    run_instr("JMPm", 16'h90FE, 0, 4'hF, 4'hE, 16'hFFFE, 0, 0, 4'h0, 0, 4'h0, 16'h0001, 16'hFFFF);
    run_instr("WRAP", 16'hB000, 0, 4'h0, 4'h0, 16'h0000, 0, 0, 4'h0, 0, 4'h0, 16'h0000, 16'h0000);
    run_instr("JMPa", 16'h900F, 0, 4'h0, 4'hF, 16'h000F, 0, 0, 4'h0, 0, 4'h0, 16'h0001, 16'h0010);
    run_instr("JMPb", 16'h90F0, 0, 4'hF, 4'h0, 16'hFFF0, 0, 0, 4'h0, 0, 4'h0, 16'h0011, 16'h0001);
    run_instr("JMPc", 16'h900E, 0, 4'h0, 4'hE, 16'h000E, 0, 0, 4'h0, 0, 4'h0, 16'h0002, 16'h0010);
    run_instr("BEQ0", 16'hA002, 0, 4'h0, 4'h2, 16'h0002, 0, 0, 4'h8, 0, 4'h0, 16'h0011, 16'h0011);
    run_instr("BEQ1", 16'hA002, 1, 4'h0, 4'h2, 16'h0002, 0, 0, 4'h8, 0, 4'h0, 16'h0012, 16'h0014);
`else
    run_instr("JMPn", 16'h90F0, 0, 4'hF, 4'h0, 16'hFFF0, 0, 0, 4'h0, 0, 4'h0, 16'h0006, 16'h0006);
    run_instr("BEQn", 16'hA002, 1, 4'h0, 4'h2, 16'h0002, 0, 0, 4'h0, 0, 4'h0, 16'h0007, 16'h0007);
`endif

    // HALT: PARADO is terminal and fetch stays blocked
    instr = 16'hF000; instr_valido = 1'b1;
    #1 chk("HALT.aceita", {15'd0, instr_aceita}, 16'd1);
    @(negedge clk);
    instr_valido = 1'b0;
    @(negedge clk);
    chk("HALT.ula_en", {15'd0, ula_en}, 16'd0);
    @(negedge clk);
    chk("HALT.parado", {15'd0, parado}, 16'd1);
    chk("HALT.RW", {15'd0, RW}, 16'd0);
    instr = 16'h0312; instr_valido = 1'b1;
    for (int k = 0; k < 20; k++) begin
      #1 chk("HALT.hold.aceita", {15'd0, instr_aceita}, 16'd0);
      chk("HALT.hold.parado", {15'd0, parado}, 16'd1);
      @(negedge clk);
    end
    instr_valido = 1'b0;

    // Reset exits PARADO
    do_reset();

    // Reset asserted in the middle of ESCRITA acts without a clock edge
    instr = 16'h0312; instr_valido = 1'b1;
    @(negedge clk);
    instr_valido = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 chk("MID.RW.before", {15'd0, RW}, 16'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("MID.RW", {15'd0, RW}, 16'd0);
    chk("MID.pc", pc, 16'd0);
    chk("MID.regC", {12'd0, regC}, 16'd0);
    chk("MID.parado", {15'd0, parado}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_instr("POST", 16'h2765, 0, 4'h6, 4'h5, 16'h0065, 0, 1, 4'h2, 1, 4'h7, 16'h0001, 16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
